mask_hud_ctrl: RTL and testbench

Sequencer for the health-mask HUD. It tracks `Player_Life` once per frame and animates mask loss and regain one mask at a time. For every pixel it decides which mask slot, if any, is under the beam and which sprite variant that slot shows. It drives the shared HP sprite ROM address and a mask-enable to the mask pixel mapper. This replaces per-mask fixed placement with a single scheduled ROM user.

---
 rtl/mask_hud_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mask_hud_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mask_hud_ctrl.sv
// Health-mask HUD sequencer: animates mask loss/regain one mask per animation and
// drives the shared HP sprite ROM address plus mask enable, registered one pixel clock.
module mask_hud_ctrl #(
  parameter int MAX_MASKS   = 5,
  parameter int MASK_W      = 12,
  parameter int MASK_H      = 16,
  parameter int HUD_X0      = 40,
  parameter int HUD_Y0      = 24,
  parameter int MASK_PITCH  = 16,
  parameter int ANIM_FRAMES = 8
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [3:0] Player_Life,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  output logic [9:0] rom_address,
  output logic       mask_on,
  output logic [3:0] displayed_life,
  output logic       anim_busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, BREAK = 2'd1, REGAIN = 2'd2} state_t;

  localparam logic [9:0] SPR_SZ    = 10'(MASK_W * MASK_H);
  localparam logic [3:0] MAX_L     = 4'(MAX_MASKS);
  localparam logic [3:0] LAST_CNT  = 4'(ANIM_FRAMES - 1);
  localparam logic [1:0] SPR_FULL  = 2'd0;
  localparam logic [1:0] SPR_CRACK = 2'd1;
  localparam logic [1:0] SPR_EMPTY = 2'd2;

  logic fclk_meta_q, fclk_sync_q, fclk_prev_q, frame_tick_q;

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      fclk_meta_q  <= 1'b0;
      fclk_sync_q  <= 1'b0;
      fclk_prev_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      fclk_meta_q  <= frame_clk;
      fclk_sync_q  <= fclk_meta_q;
      fclk_prev_q  <= fclk_sync_q;
      frame_tick_q <= fclk_sync_q & ~fclk_prev_q;
    end
  end

  state_t     state_q, state_d;
  logic [3:0] shown_q, shown_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] slot_q, slot_d;
  logic [3:0] target, cnt_inc;
  logic       busy_q;

  assign target  = (Player_Life > MAX_L) ? MAX_L : Player_Life;
  assign cnt_inc = cnt_q + 4'd1;

  // The entering tick counts as the first animation frame, so completion is
  // judged on the incremented count.
  always_comb begin
    state_d = state_q;
    shown_d = shown_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    if (frame_tick_q) begin
      case (state_q)
        IDLE: begin
          if (target < shown_q) begin
            state_d = BREAK;
            slot_d  = shown_q - 4'd1;
            cnt_d   = 4'd0;
          end else if (target > shown_q) begin
            state_d = REGAIN;
            slot_d  = shown_q;
            cnt_d   = 4'd0;
          end
        end
        BREAK, REGAIN: begin
          if (cnt_inc == LAST_CNT) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            shown_d = (state_q == BREAK) ? shown_q - 4'd1 : shown_q + 4'd1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      shown_q <= MAX_L;
      cnt_q   <= 4'd0;
      slot_q  <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shown_q <= shown_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  logic        hit, y_in;
  logic [3:0]  hit_slot;
  logic [9:0]  lx, ly;
  logic [10:0] x0;
  logic [1:0]  sel;
  logic [9:0]  addr_d;
  logic        mask_on_q;
  logic [9:0]  addr_q;

  assign y_in = ({1'b0, DrawY} >= 11'(HUD_Y0)) && ({1'b0, DrawY} < 11'(HUD_Y0 + MASK_H));
  assign ly   = DrawY - 10'(HUD_Y0);

  always_comb begin
    hit      = 1'b0;
    hit_slot = 4'd0;
    lx       = 10'd0;
    x0       = 11'd0;
    for (int i = 0; i < MAX_MASKS; i++) begin
      x0 = 11'(HUD_X0 + i * MASK_PITCH);
      if (blank && y_in && ({1'b0, DrawX} >= x0) && ({1'b0, DrawX} < x0 + 11'(MASK_W))) begin
        hit      = 1'b1;
        hit_slot = 4'(i);
        lx       = DrawX - x0[9:0];
      end
    end
  end

  always_comb begin
    sel = (hit_slot < shown_q) ? SPR_FULL : SPR_EMPTY;
    if (hit_slot == slot_q) begin
      if (state_q == BREAK) begin
        sel = SPR_CRACK;
      end else if (state_q == REGAIN) begin
        sel = cnt_q[1] ? SPR_FULL : SPR_EMPTY;
      end
    end
  end

  assign addr_d = hit ? (10'(sel) * SPR_SZ + ly * 10'(MASK_W) + lx) : 10'd0;

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      mask_on_q <= 1'b0;
      addr_q    <= 10'd0;
    end else begin
      mask_on_q <= hit;
      addr_q    <= addr_d;
    end
  end

  assign rom_address    = addr_q;
  assign mask_on        = mask_on_q;
  assign displayed_life = shown_q;
  assign anim_busy      = busy_q;

endmodule

// File: tb/tb_mask_hud_ctrl.sv
// Bench for mask_hud_ctrl: directed pixel probes and frame strobes, expected
// outputs queued at stimulus time and checked by a separate monitor.
module tb_mask_hud_ctrl;

  logic       vga_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [3:0] Player_Life = 4'd5;
  logic [9:0] DrawX = 10'd0;
  logic [9:0] DrawY = 10'd0;
  logic       blank = 1'b0;
  logic [9:0] rom_address;
  logic       mask_on;
  logic [3:0] displayed_life;
  logic       anim_busy;

  mask_hud_ctrl dut (
    .vga_clk(vga_clk), .Reset(Reset), .frame_clk(frame_clk), .Player_Life(Player_Life),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .rom_address(rom_address),
    .mask_on(mask_on), .displayed_life(displayed_life), .anim_busy(anim_busy)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    string       name;
    logic [15:0] want;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic probe_vld = 1'b0;
  logic probe_d = 1'b0;

  // Output packing: {mask_on, rom_address, displayed_life, anim_busy}
  always @(posedge vga_clk) probe_d <= probe_vld;

  always @(negedge vga_clk) begin
    if (probe_d) begin
      exp_t e;
      logic [15:0] got;
      got = {mask_on, rom_address, displayed_life, anim_busy};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: output presented with no expectation, got %h", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e.want) begin
          errors++;
          $display("FAIL %s: got on=%b addr=%0d life=%0d busy=%b, want on=%b addr=%0d life=%0d busy=%b",
                   e.name, got[15], got[14:5], got[4:1], got[0],
                   e.want[15], e.want[14:5], e.want[4:1], e.want[0]);
        end
      end
    end
  end

  task automatic probe(input string name, input int x, input int y, input logic b,
                       input logic on, input int addr, input int life, input logic busy);
    exp_t e;
    @(posedge vga_clk);
    #1;
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    e.name = name;
    e.want = {on, 10'(addr), 4'(life), busy};
    exp_q.push_back(e);
    probe_vld = 1'b1;
    @(posedge vga_clk);
    #1;
    probe_vld = 1'b0;
    @(negedge vga_clk);
    #1;
  endtask

  task automatic check_now(input string name, input logic on, input int addr,
                           input int life, input logic busy);
    logic [15:0] got, want;
    got  = {mask_on, rom_address, displayed_life, anim_busy};
    want = {on, 10'(addr), 4'(life), busy};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got on=%b addr=%0d life=%0d busy=%b, want on=%b addr=%0d life=%0d busy=%b",
               name, got[15], got[14:5], got[4:1], got[0],
               want[15], want[14:5], want[4:1], want[0]);
    end
  endtask

  task automatic frame_pulse();
    @(posedge vga_clk);
    #1 frame_clk = 1'b1;
    repeat (5) @(posedge vga_clk);
    #1 frame_clk = 1'b0;
    repeat (5) @(posedge vga_clk);
  endtask

  initial begin
    int addr;
    // Reset state
    repeat (3) @(posedge vga_clk);
    #1 check_now("reset_state", 1'b0, 0, 5, 1'b0);
    @(negedge vga_clk);
    Reset = 1'b0;

    // One frame at full life, pixel mapping
    frame_pulse();
    probe("slot0_origin", 40, 24, 1'b1, 1'b1, 0, 5, 1'b0);
    probe("gap_52", 52, 24, 1'b1, 1'b0, 0, 5, 1'b0);
    probe("slot0_corner", 51, 39, 1'b1, 1'b1, 191, 5, 1'b0);
    probe("below_hud", 40, 40, 1'b1, 1'b0, 0, 5, 1'b0);
    probe("left_of_hud", 39, 24, 1'b1, 1'b0, 0, 5, 1'b0);

    // Single break 5 -> 4
    Player_Life = 4'd4;
    for (int t = 1; t <= 8; t++) begin
      frame_pulse();
      if (t == 1) begin
        probe("break_slot4_cracked", 104, 24, 1'b1, 1'b1, 192, 5, 1'b1);
        probe("break_slot3_full", 90, 26, 1'b1, 1'b1, 26, 5, 1'b1);
      end else begin
        probe("single_break", 0, 0, 1'b1, 1'b0, 0, (t == 8) ? 4 : 5, t != 8);
      end
    end
    probe("slot4_empty", 104, 24, 1'b1, 1'b1, 384, 4, 1'b0);

    // Multi-step loss 4 -> 2, one mask per animation
    Player_Life = 4'd2;
    for (int t = 1; t <= 17; t++) begin
      frame_pulse();
      probe("multi_loss", 0, 0, 1'b1, 1'b0, 0,
            4 - ((t >= 8) ? 1 : 0) - ((t >= 16) ? 1 : 0), !(t == 8 || t >= 16));
      if (t == 10) probe("multi_slot2_cracked", 72, 24, 1'b1, 1'b1, 192, 3, 1'b1);
    end

    // Regain 2 -> 3 with reversal requested at tick 4; slot 2 observed throughout
    Player_Life = 4'd4;
    for (int t = 1; t <= 16; t++) begin
      frame_pulse();
      if (t == 3) Player_Life = 4'd2;
      if (t <= 7)       addr = (((t - 1) & 2) != 0) ? 0 : 384;
      else if (t == 8)  addr = 0;
      else if (t <= 15) addr = 192;
      else              addr = 384;
      probe("regain_reversal", 72, 24, 1'b1, 1'b1, addr,
            (t >= 8 && t <= 15) ? 3 : 2, !(t == 8 || t == 16));
    end

    // Player_Life above MAX_MASKS clamps to 5
    Player_Life = 4'd15;
    for (int t = 1; t <= 24; t++) begin
      frame_pulse();
      probe("clamp_regain", 0, 0, 1'b1, 1'b0, 0, 2 + t / 8, (t % 8) != 0);
    end
    frame_pulse();
    probe("clamp_full_idle", 0, 0, 1'b1, 1'b0, 0, 5, 1'b0);
    probe("blank_low", 41, 25, 1'b0, 1'b0, 0, 5, 1'b0);
    probe("blank_high", 41, 25, 1'b1, 1'b1, 13, 5, 1'b0);

    // Loss down to zero, then stay idle
    Player_Life = 4'd0;
    for (int t = 1; t <= 40; t++) begin
      frame_pulse();
      probe("loss_to_zero", 0, 0, 1'b1, 1'b0, 0, 5 - t / 8, (t % 8) != 0);
    end
    frame_pulse();
    probe("zero_idle", 40, 24, 1'b1, 1'b1, 384, 0, 1'b0);

    // Reset asserted during a break
    @(posedge vga_clk);
    #1 Reset = 1'b1;
    @(negedge vga_clk);
    Reset = 1'b0;
    Player_Life = 4'd4;
    for (int t = 1; t <= 5; t++) frame_pulse();
    @(posedge vga_clk);
    #1;
    DrawX = 10'd104;
    DrawY = 10'd24;
    blank = 1'b1;
    @(posedge vga_clk);
    #2 check_now("pre_reset_break", 1'b1, 192, 5, 1'b1);
    #1 Reset = 1'b1;
    #1 check_now("mid_anim_reset", 1'b0, 0, 5, 1'b0);
    Player_Life = 4'd5;
    @(negedge vga_clk);
    Reset = 1'b0;
    frame_pulse();
    probe("after_reset_idle", 0, 0, 1'b1, 1'b0, 0, 5, 1'b0);

    repeat (3) @(posedge vga_clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover: %0d expectations never matched, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
